// File: rtl/ad9912_spi_pkg.sv
// ---------------------------------------------------------------------------
// ad9912_spi_pkg
// Shared definitions for the AD9912 serial-port responder:
//   - bit positions of the fields inside the 16-bit instruction word
//   - W1:W0 byte-count codes
//   - responder state encoding
// ---------------------------------------------------------------------------
package ad9912_spi_pkg;

    // Instruction word layout (MSB first on the wire)
    localparam int RW_BIT   = 15;   // 1 = read
    localparam int W_MSB    = 14;
    localparam int W_LSB    = 13;
    localparam int ADDR_MSB = 12;

    // W1:W0 byte-count codes
    localparam logic [1:0] W_ONE    = 2'b00;
    localparam logic [1:0] W_TWO    = 2'b01;
    localparam logic [1:0] W_THREE  = 2'b10;
    localparam logic [1:0] W_STREAM = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INSTR   = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/spi_input_sync.sv
// ---------------------------------------------------------------------------
// spi_input_sync
// Multi-flop synchronizer followed by a registered edge detector.
// The level, rise and fall outputs are all registered one clk after the last
// synchronizer stage, so they are mutually aligned and arrive SYNC_STAGES+1
// clk after the pin changes. SYNC_STAGES must be 2 or more.
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   i_d       asynchronous input pin
//   o_level   synchronized level
//   o_rise    one-clk pulse on a 0->1 transition of the synchronized level
//   o_fall    one-clk pulse on a 1->0 transition of the synchronized level
// ---------------------------------------------------------------------------
module spi_input_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0   // idle level of the pin
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= {SYNC_STAGES{RESET_VAL}};
            r_level <= RESET_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_level <= w_sync_out;
            r_rise  <= w_sync_out & ~r_level;
            r_fall  <= ~w_sync_out & r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ad9912_spi_responder.sv
// ---------------------------------------------------------------------------
// ad9912_spi_responder
// DDS-side responder for AD9912 3-wire SPI frames. Decodes the 16-bit
// instruction, emits one write strobe per completed data byte, and serves
// read frames from an external register-read port.
//
// Ports:
//   clk, reset_n        system clock (>= 4x SCLK), async active-low reset
//   spi_sclk/csb/sdio_in  SPI pins from the controller (asynchronous)
//   spi_sdo, spi_sdo_oe   read data and its output enable for shared SDIO
//   wr_valid/addr/data    one-clk write strobe per completed write byte
//   rd_req, rd_addr       one-clk read request
//   rd_data               read byte, sampled the clk after rd_req
//   busy                  frame in progress
//   frame_error           one-clk pulse when CSB rises mid-byte
// ---------------------------------------------------------------------------
module ad9912_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spi_sclk,
    input  logic                  spi_csb,
    input  logic                  spi_sdio_in,
    output logic                  spi_sdo,
    output logic                  spi_sdo_oe,
    output logic                  wr_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [7:0]            rd_data,
    output logic                  busy,
    output logic                  frame_error
);
    import ad9912_spi_pkg::*;

    logic w_sclk_level_unused, w_sclk_rise, w_sclk_fall;
    logic w_csb_level, w_csb_rise, w_csb_fall;
    logic w_sdio, w_sdio_rise_unused, w_sdio_fall_unused;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .i_d(spi_sclk),
        .o_level(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));

    // CSB idles high; resetting its synchronizer high avoids a spurious edge.
    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csb (
        .clk(clk), .reset_n(reset_n), .i_d(spi_csb),
        .o_level(w_csb_level), .o_rise(w_csb_rise), .o_fall(w_csb_fall));

    // SDIO goes through the same registered path so its level lines up with
    // the detected SCLK edge.
    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdio (
        .clk(clk), .reset_n(reset_n), .i_d(spi_sdio_in),
        .o_level(w_sdio), .o_rise(w_sdio_rise_unused), .o_fall(w_sdio_fall_unused));

    state_t                r_state, w_state_next;
    logic [15:0]           r_shift, w_shift_next;
    logic [3:0]            r_bit_cnt, w_bit_cnt_next;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
    logic [1:0]            r_bytes_left, w_bytes_left_next;
    logic                  r_stream, w_stream_next;
    logic                  r_wr_valid, w_wr_valid_next;
    logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_next;
    logic [7:0]            r_wr_data, w_wr_data_next;
    logic                  r_rd_req, w_rd_req_next;
    logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_next;
    logic [7:0]            r_sdo_shift, w_sdo_shift_next;
    logic                  r_frame_error, w_frame_error_next;

    logic [15:0]           w_shifted;      // shift register with the new bit appended
    logic                  w_sclk_rise_act;
    logic                  w_sclk_fall_act;

    assign w_shifted       = {r_shift[14:0], w_sdio};
    assign w_sclk_rise_act = w_sclk_rise & ~w_csb_level;
    assign w_sclk_fall_act = w_sclk_fall & ~w_csb_level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_addr        <= '0;
            r_bytes_left  <= '0;
            r_stream      <= 1'b0;
            r_wr_valid    <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_rd_req      <= 1'b0;
            r_rd_addr     <= '0;
            r_sdo_shift   <= '0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_shift       <= w_shift_next;
            r_bit_cnt     <= w_bit_cnt_next;
            r_addr        <= w_addr_next;
            r_bytes_left  <= w_bytes_left_next;
            r_stream      <= w_stream_next;
            r_wr_valid    <= w_wr_valid_next;
            r_wr_addr     <= w_wr_addr_next;
            r_wr_data     <= w_wr_data_next;
            r_rd_req      <= w_rd_req_next;
            r_rd_addr     <= w_rd_addr_next;
            r_sdo_shift   <= w_sdo_shift_next;
            r_frame_error <= w_frame_error_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_shift_next       = r_shift;
        w_bit_cnt_next     = r_bit_cnt;
        w_addr_next        = r_addr;
        w_bytes_left_next  = r_bytes_left;
        w_stream_next      = r_stream;
        w_wr_valid_next    = 1'b0;
        w_wr_addr_next     = r_wr_addr;
        w_wr_data_next     = r_wr_data;
        w_rd_req_next      = 1'b0;
        w_rd_addr_next     = r_rd_addr;
        w_sdo_shift_next   = r_sdo_shift;
        w_frame_error_next = 1'b0;

        if (w_csb_rise) begin
            // CSB rising wins over any SCLK edge in the same clk.
            if ((r_state == ST_INSTR || r_state == ST_WR_DATA || r_state == ST_RD_DATA)
                && r_bit_cnt != 4'd0) begin
                w_frame_error_next = 1'b1;
            end
            w_state_next   = ST_IDLE;
            w_bit_cnt_next = '0;
        end else if (w_csb_fall) begin
            w_state_next   = ST_INSTR;
            w_bit_cnt_next = '0;
            w_shift_next   = '0;
        end else begin
            case (r_state)
                ST_INSTR: begin
                    if (w_sclk_rise_act) begin
                        w_shift_next = w_shifted;
                        if (r_bit_cnt == 4'd15) begin
                            w_bit_cnt_next    = '0;
                            w_addr_next       = w_shifted[ADDR_WIDTH-1:0];
                            w_bytes_left_next = w_shifted[W_MSB:W_LSB];
                            w_stream_next     = (w_shifted[W_MSB:W_LSB] == W_STREAM);
                            if (w_shifted[RW_BIT]) begin
                                w_state_next   = ST_RD_DATA;
                                w_rd_req_next  = 1'b1;
                                w_rd_addr_next = w_shifted[ADDR_WIDTH-1:0];
                            end else begin
                                w_state_next = ST_WR_DATA;
                            end
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 4'd1;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (w_sclk_rise_act) begin
                        w_shift_next = w_shifted;
                        if (r_bit_cnt == 4'd7) begin
                            w_bit_cnt_next  = '0;
                            w_wr_valid_next = 1'b1;
                            w_wr_addr_next  = r_addr;
                            w_wr_data_next  = w_shifted[7:0];
                            w_addr_next     = r_addr - 1'b1;
                            if (!r_stream) begin
                                if (r_bytes_left == 2'd0) begin
                                    w_state_next = ST_DONE;
                                end else begin
                                    w_bytes_left_next = r_bytes_left - 2'd1;
                                end
                            end
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 4'd1;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (w_sclk_rise_act) begin
                        if (r_bit_cnt == 4'd7) begin
                            w_bit_cnt_next = '0;
                            w_addr_next    = r_addr - 1'b1;
                            if (r_stream || r_bytes_left != 2'd0) begin
                                w_rd_req_next  = 1'b1;
                                w_rd_addr_next = r_addr - 1'b1;
                                if (!r_stream) begin
                                    w_bytes_left_next = r_bytes_left - 2'd1;
                                end
                            end else begin
                                w_state_next = ST_DONE;
                            end
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 4'd1;
                        end
                    end else if (w_sclk_fall_act && r_bit_cnt != 4'd0) begin
                        // The falling edge right after a byte boundary must
                        // keep the freshly loaded MSB on the line.
                        w_sdo_shift_next = {r_sdo_shift[6:0], 1'b0};
                    end
                end
                default: ;
            endcase
            // Read data arrives one clk after the request and replaces the
            // shift register contents.
            if (r_rd_req) begin
                w_sdo_shift_next = rd_data;
            end
        end
    end

    assign spi_sdo     = r_sdo_shift[7];
    assign spi_sdo_oe  = (r_state == ST_RD_DATA) && !w_csb_level && !w_csb_rise;
    assign wr_valid    = r_wr_valid;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign rd_req      = r_rd_req;
    assign rd_addr     = r_rd_addr;
    assign busy        = (r_state != ST_IDLE);
    assign frame_error = r_frame_error;

endmodule

// File: tb/tb_ad9912_spi_responder.sv
module tb_ad9912_spi_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        spi_sclk;
    logic        spi_csb;
    logic        spi_sdio_in;
    logic        spi_sdo;
    logic        spi_sdo_oe;
    logic        wr_valid;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_req;
    logic [12:0] rd_addr;
    logic [7:0]  rd_data;
    logic        busy;
    logic        frame_error;

    always #5 clk = ~clk;

    ad9912_spi_responder #(.SYNC_STAGES(2), .ADDR_WIDTH(13)) dut (
        .clk(clk), .reset_n(reset_n),
        .spi_sclk(spi_sclk), .spi_csb(spi_csb), .spi_sdio_in(spi_sdio_in),
        .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .frame_error(frame_error));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Event monitor, sampled on the falling clk edge
    int          wr_total = 0;
    int          rd_total = 0;
    int          fe_total = 0;
    logic [12:0] wr_log_addr [64];
    logic [7:0]  wr_log_data [64];
    logic [12:0] rd_log_addr [64];

    always @(negedge clk) begin
        if (wr_valid) begin
            if (wr_total < 64) begin
                wr_log_addr[wr_total] = wr_addr;
                wr_log_data[wr_total] = wr_data;
            end
            wr_total++;
        end
        if (rd_req) begin
            if (rd_total < 64) rd_log_addr[rd_total] = rd_addr;
            rd_total++;
        end
        if (frame_error) fe_total++;
    end

    // SPI controller model: SCLK half period = 8 clk
    logic cap_sdo [64];
    logic cap_oe  [64];
    int   cap_n;
    logic busy_mid;

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b);
        spi_sdio_in = b;
        wait_clks(8);
        if (cap_n < 64) begin
            cap_sdo[cap_n] = spi_sdo;
            cap_oe[cap_n]  = spi_sdo_oe;
        end
        cap_n++;
        spi_sclk = 1'b1;
        wait_clks(8);
        spi_sclk = 1'b0;
    endtask

    task automatic frame_start();
        cap_n   = 0;
        spi_csb = 1'b0;
        wait_clks(8);
    endtask

    task automatic frame_end();
        wait_clks(8);
        spi_csb = 1'b1;
        wait_clks(10);
    endtask

    task automatic send_frame(input logic [15:0] instr, input int ibits,
                              input logic [31:0] data, input int nbits);
        frame_start();
        for (int i = 0; i < ibits; i++) begin
            spi_bit(instr[15-i]);
            if (i == 0) busy_mid = busy;
        end
        for (int i = 0; i < nbits; i++) spi_bit(data[31-i]);
        frame_end();
    endtask

    typedef struct {
        logic [15:0] instr;
        int          ibits;
        logic [31:0] data;
        int          nbits;
        int          exp_n;
        logic [38:0] exp_addr;   // up to three 13-bit addresses, first in the MSBs
        logic [23:0] exp_data;   // up to three bytes, first in the MSBs
        int          exp_fe;
    } vec_t;

    vec_t        vecs [7];
    int          wb, rb, fb;
    logic [38:0] ea;
    logic [23:0] ed;
    logic [7:0]  rx_byte;
    logic        oe_any, oe_all;

    initial begin
        vecs[0] = '{16'h21A6, 16, 32'h1234_0000, 16, 2, {13'h1A6, 13'h1A5, 13'h0000}, 24'h1234_00, 0};
        vecs[1] = '{16'h6001, 16, 32'hAABB_CC00, 24, 3, {13'h0001, 13'h0000, 13'h1FFF}, 24'hAABBCC, 0};
        vecs[2] = '{16'h0010, 16, 32'hC33C_0000, 16, 1, {13'h0010, 13'h0000, 13'h0000}, 24'hC3_0000, 0};
        vecs[3] = '{16'h0003, 16, 32'h5A00_0000,  8, 1, {13'h0003, 13'h0000, 13'h0000}, 24'h5A_0000, 0};
        vecs[4] = '{16'h4100, 16, 32'h7700_0000,  8, 1, {13'h0100, 13'h0000, 13'h0000}, 24'h77_0000, 0};
        vecs[5] = '{16'h2050, 16, 32'hF0F0_0000, 12, 1, {13'h0050, 13'h0000, 13'h0000}, 24'hF0_0000, 1};
        vecs[6] = '{16'hABCD, 12, 32'h0000_0000,  0, 0, {13'h0000, 13'h0000, 13'h0000}, 24'h00_0000, 1};

        reset_n     = 1'b0;
        spi_sclk    = 1'b0;
        spi_csb     = 1'b1;
        spi_sdio_in = 1'b0;
        rd_data     = 8'h00;
        cap_n       = 0;
        busy_mid    = 1'b0;
        wait_clks(3);
        check("reset_outputs",
              64'({spi_sdo, spi_sdo_oe, wr_valid, wr_addr, wr_data, rd_req, rd_addr, busy, frame_error}),
              64'd0);
        reset_n = 1'b1;
        wait_clks(5);

        // SCLK toggling with CSB high must be ignored
        wb = wr_total; fb = fe_total;
        for (int i = 0; i < 4; i++) begin
            spi_sclk = 1'b1; wait_clks(4);
            spi_sclk = 1'b0; wait_clks(4);
        end
        wait_clks(5);
        check("idle_sclk_busy", 64'(busy), 64'd0);
        check("idle_sclk_events", 64'((wr_total - wb) + (fe_total - fb)), 64'd0);
        $display("txn idle_sclk busy=%0d writes=%0d", busy, wr_total - wb);

        // Table-driven write / abort frames
        for (int v = 0; v < 7; v++) begin
            wb = wr_total; rb = rd_total; fb = fe_total;
            send_frame(vecs[v].instr, vecs[v].ibits, vecs[v].data, vecs[v].nbits);
            check($sformatf("v%0d_wr_count", v), 64'(wr_total - wb), 64'(vecs[v].exp_n));
            ea = vecs[v].exp_addr;
            ed = vecs[v].exp_data;
            for (int k = 0; k < vecs[v].exp_n; k++) begin
                if (wb + k < 64 && k < wr_total - wb) begin
                    check($sformatf("v%0d_wr_addr%0d", v, k), 64'(wr_log_addr[wb+k]), 64'(ea[38-13*k -: 13]));
                    check($sformatf("v%0d_wr_data%0d", v, k), 64'(wr_log_data[wb+k]), 64'(ed[23-8*k -: 8]));
                end
            end
            check($sformatf("v%0d_frame_error", v), 64'(fe_total - fb), 64'(vecs[v].exp_fe));
            check($sformatf("v%0d_rd_count", v), 64'(rd_total - rb), 64'd0);
            check($sformatf("v%0d_busy_mid", v), 64'(busy_mid), 64'd1);
            check($sformatf("v%0d_busy_end", v), 64'(busy), 64'd0);
            $display("txn v%0d instr=0x%04h ibits=%0d dbits=%0d writes=%0d frame_errors=%0d",
                     v, vecs[v].instr, vecs[v].ibits, vecs[v].nbits, wr_total - wb, fe_total - fb);
        end

        // 1-byte read from 0x0005 returning 0xA5
        rd_data = 8'hA5;
        wb = wr_total; rb = rd_total; fb = fe_total;
        send_frame(16'h8005, 16, 32'h0, 8);
        check("rd_count", 64'(rd_total - rb), 64'd1);
        if (rd_total > rb && rb < 64) check("rd_addr", 64'(rd_log_addr[rb]), 64'h0005);
        rx_byte = '0;
        for (int i = 0; i < 8; i++) rx_byte = {rx_byte[6:0], cap_sdo[16+i]};
        check("rd_sdo_bits", 64'(rx_byte), 64'hA5);
        oe_any = 1'b0;
        for (int i = 0; i < 16; i++) oe_any = oe_any | cap_oe[i];
        oe_all = 1'b1;
        for (int i = 16; i < 24; i++) oe_all = oe_all & cap_oe[i];
        check("rd_oe_instr_phase", 64'(oe_any), 64'd0);
        check("rd_oe_data_phase", 64'(oe_all), 64'd1);
        check("rd_oe_after_frame", 64'(spi_sdo_oe), 64'd0);
        check("rd_no_writes_errors", 64'((wr_total - wb) + (fe_total - fb)), 64'd0);
        $display("txn read instr=0x8005 rd_reqs=%0d byte=0x%02h", rd_total - rb, rx_byte);

        // Reset asserted after 4 data bits of a write
        wb = wr_total; fb = fe_total;
        frame_start();
        for (int i = 0; i < 16; i++) spi_bit(1'(16'h2123 >> (15 - i)));
        spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1);
        wait_clks(2);
        reset_n  = 1'b0;
        spi_csb  = 1'b1;
        spi_sclk = 1'b0;
        wait_clks(2);
        check("midreset_outputs",
              64'({spi_sdo, spi_sdo_oe, wr_valid, wr_addr, wr_data, rd_req, rd_addr, busy, frame_error}),
              64'd0);
        reset_n = 1'b1;
        wait_clks(10);
        check("midreset_no_events", 64'((wr_total - wb) + (fe_total - fb)), 64'd0);
        $display("txn reset_mid_frame writes=%0d frame_errors=%0d", wr_total - wb, fe_total - fb);

        wb = wr_total;
        send_frame(16'h0042, 16, 32'h9900_0000, 8);
        check("post_reset_wr_count", 64'(wr_total - wb), 64'd1);
        if (wr_total > wb && wb < 64) begin
            check("post_reset_wr_addr", 64'(wr_log_addr[wb]), 64'h0042);
            check("post_reset_wr_data", 64'(wr_log_data[wb]), 64'h99);
        end
        $display("txn post_reset instr=0x0042 writes=%0d", wr_total - wb);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the bench always ends
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
